// File: rtl/gravsim_regmap_pkg.sv
// Register map, field layout and helper functions shared by the
// N-body register file and its control FSM.
package gravsim_regmap_pkg;

    localparam int REG_G      = 0;
    localparam int REG_NUM    = 1;
    localparam int REG_CTRL   = 2;
    localparam int REG_STATUS = 3;
    localparam int FIELD_BASE = 4;
    localparam int NUM_FIELDS = 11;

    typedef enum logic [3:0] {
        MASS, RAD,
        POS_X, POS_Y, POS_Z,
        VEL_X, VEL_Y, VEL_Z,
        ACC_X, ACC_Y, ACC_Z
    } body_field_e;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } ctrl_state_e;

    function automatic int body_addr(body_field_e field, int body, int max_bodies);
        return FIELD_BASE + int'(field) * max_bodies + body;
    endfunction

    function automatic logic [31:0] be_merge(logic [31:0] old_word,
                                             logic [31:0] new_word,
                                             logic [3:0]  be);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++)
            merged[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
        return merged;
    endfunction

endpackage

// File: rtl/regfile_ctrl_fsm.sv
// Start/done handshake between the Nios II bus and the physics engine,
// including the sticky DONE flag, IRQ enable and the level interrupt.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | engine stopped; a START write launches it
// ST_BUSY | engine running; owns its ports until ENG_DONE
module regfile_ctrl_fsm
    import gravsim_regmap_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       ctrl_wr,
    input  logic       status_wr,
    input  logic [1:0] wdata_lo,
    input  logic       eng_done,
    output logic       eng_start,
    output logic       busy,
    output logic       done,
    output logic       irq_en,
    output logic       irq
);

    ctrl_state_e state, state_nxt;
    logic        done_nxt, start_nxt, irq_en_nxt;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= ST_IDLE;
            done      <= 1'b0;
            eng_start <= 1'b0;
            irq_en    <= 1'b0;
        end else begin
            state     <= state_nxt;
            done      <= done_nxt;
            eng_start <= start_nxt;
            irq_en    <= irq_en_nxt;
        end
    end

    // Transition updates to DONE come after the W1C so a same-edge ENG_DONE wins.
    always_comb begin
        state_nxt  = state;
        done_nxt   = done;
        start_nxt  = 1'b0;
        irq_en_nxt = irq_en;
        if (ctrl_wr)
            irq_en_nxt = wdata_lo[1];
        if (status_wr && wdata_lo[0])
            done_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ctrl_wr && wdata_lo[0]) begin
                    state_nxt = ST_BUSY;
                    start_nxt = 1'b1;
                    done_nxt  = 1'b0;
                end
            end
            ST_BUSY: begin
                if (eng_done) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_BUSY);
    assign irq  = done & irq_en;

endmodule

// File: rtl/body_regfile_avl.sv
// Avalon-MM register file holding N-body constants and per-body state,
// shared between the Nios II bus and the multi-port physics engine.
module body_regfile_avl
    import gravsim_regmap_pkg::*;
#(
    parameter int MAX_BODIES  = 10,
    parameter int NPORT       = 6,
    parameter int N_DISP      = 4,
    parameter int ADDR_W      = 8,
    parameter int EXPORT_ADDR = 0
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic                          AVL_READ,
    input  logic                          AVL_WRITE,
    input  logic                          AVL_CS,
    input  logic [3:0]                    AVL_BYTE_EN,
    input  logic [ADDR_W-1:0]             AVL_ADDR,
    input  logic [31:0]                   AVL_WRITEDATA,
    output logic [31:0]                   AVL_READDATA,
    output logic                          AVL_READDATAVALID,
    output logic                          AVL_IRQ,
    output logic                          ENG_START,
    input  logic                          ENG_DONE,
    input  logic                          ENG_CLEAR_ACC,
    input  logic [NPORT-1:0][ADDR_W-1:0]  ENG_ADDR,
    input  logic [NPORT-1:0]              ENG_WE,
    input  logic [NPORT-1:0]              ENG_RE,
    input  logic [NPORT-1:0][31:0]        ENG_WDATA,
    output logic [NPORT-1:0][31:0]        ENG_RDATA,
    output logic [31:0]                   CFG_G,
    output logic [31:0]                   CFG_NUM,
    output logic [N_DISP-1:0][31:0]       DISP_RAD,
    output logic [N_DISP-1:0][31:0]       DISP_POS_X,
    output logic [N_DISP-1:0][31:0]       DISP_POS_Y,
    output logic [N_DISP-1:0][31:0]       DISP_POS_Z,
    output logic [31:0]                   EXPORT_DATA
);

    localparam int DEPTH    = FIELD_BASE + NUM_FIELDS * MAX_BODIES;
    localparam int ACC_BASE = FIELD_BASE + int'(ACC_X) * MAX_BODIES;

    logic [31:0] mem     [DEPTH];
    logic [31:0] mem_nxt [DEPTH];
    logic [31:0] view    [DEPTH];

    logic                   bus_wr, bus_rd, ctrl_wr, status_wr;
    logic                   busy, done, irq_en;
    logic [31:0]            bus_rval;
    logic [NPORT-1:0][31:0] eng_rval;

    assign bus_wr    = AVL_CS & AVL_WRITE;
    assign bus_rd    = AVL_CS & AVL_READ;
    assign ctrl_wr   = bus_wr && (AVL_ADDR == ADDR_W'(REG_CTRL))   && AVL_BYTE_EN[0];
    assign status_wr = bus_wr && (AVL_ADDR == ADDR_W'(REG_STATUS)) && AVL_BYTE_EN[0];

    regfile_ctrl_fsm u_ctrl_fsm (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .ctrl_wr   (ctrl_wr),
        .status_wr (status_wr),
        .wdata_lo  (AVL_WRITEDATA[1:0]),
        .eng_done  (ENG_DONE),
        .eng_start (ENG_START),
        .busy      (busy),
        .done      (done),
        .irq_en    (irq_en),
        .irq       (AVL_IRQ)
    );

    // CTRL and STATUS live in the FSM; their storage words stay at zero.
    always_comb begin
        for (int w = 0; w < DEPTH; w++)
            view[w] = mem[w];
        view[REG_CTRL]   = {30'b0, irq_en, 1'b0};
        view[REG_STATUS] = {30'b0, busy, done};
    end

    // Later assignments win: clear < engine port 0..NPORT-1 < Avalon.
    always_comb begin
        for (int w = 0; w < DEPTH; w++) begin
            mem_nxt[w] = mem[w];
            if (w == REG_CTRL || w == REG_STATUS) begin
                mem_nxt[w] = '0;
            end else begin
                if (busy && ENG_CLEAR_ACC && w >= ACC_BASE)
                    mem_nxt[w] = '0;
                if (busy && w >= FIELD_BASE) begin
                    for (int p = 0; p < NPORT; p++)
                        if (ENG_WE[p] && ENG_ADDR[p] == ADDR_W'(w))
                            mem_nxt[w] = ENG_WDATA[p];
                end
                if (bus_wr && AVL_ADDR == ADDR_W'(w))
                    mem_nxt[w] = be_merge(mem[w], AVL_WRITEDATA, AVL_BYTE_EN);
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int w = 0; w < DEPTH; w++)
                mem[w] <= '0;
        end else begin
            for (int w = 0; w < DEPTH; w++)
                mem[w] <= mem_nxt[w];
        end
    end

    // Addresses at or beyond DEPTH match no word and read as zero.
    always_comb begin
        bus_rval = '0;
        for (int w = 0; w < DEPTH; w++)
            if (AVL_ADDR == ADDR_W'(w))
                bus_rval = view[w];
        for (int p = 0; p < NPORT; p++) begin
            eng_rval[p] = '0;
            for (int w = 0; w < DEPTH; w++)
                if (ENG_ADDR[p] == ADDR_W'(w))
                    eng_rval[p] = view[w];
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            AVL_READDATA      <= '0;
            AVL_READDATAVALID <= 1'b0;
            ENG_RDATA         <= '0;
        end else begin
            AVL_READDATAVALID <= bus_rd;
            if (bus_rd)
                AVL_READDATA <= bus_rval;
            for (int p = 0; p < NPORT; p++)
                if (busy && ENG_RE[p])
                    ENG_RDATA[p] <= eng_rval[p];
        end
    end

    assign CFG_G       = mem[REG_G];
    assign CFG_NUM     = mem[REG_NUM];
    assign EXPORT_DATA = view[EXPORT_ADDR];

    for (genvar d = 0; d < N_DISP; d++) begin : g_disp
        localparam int A_RAD = body_addr(RAD,   d, MAX_BODIES);
        localparam int A_PX  = body_addr(POS_X, d, MAX_BODIES);
        localparam int A_PY  = body_addr(POS_Y, d, MAX_BODIES);
        localparam int A_PZ  = body_addr(POS_Z, d, MAX_BODIES);
        assign DISP_RAD[d]   = mem[A_RAD];
        assign DISP_POS_X[d] = mem[A_PX];
        assign DISP_POS_Y[d] = mem[A_PY];
        assign DISP_POS_Z[d] = mem[A_PZ];
    end

endmodule

// File: tb/tb_body_regfile_avl.sv
// Directed bench for body_regfile_avl: byte merging, start/done handshake,
// write priority, accumulator clear, range checks and mid-run reset.
module tb_body_regfile_avl;

    logic                 CLK = 1'b0;
    logic                 RESET_N;
    logic                 AVL_READ, AVL_WRITE, AVL_CS;
    logic [3:0]           AVL_BYTE_EN;
    logic [7:0]           AVL_ADDR;
    logic [31:0]          AVL_WRITEDATA, AVL_READDATA;
    logic                 AVL_READDATAVALID, AVL_IRQ, ENG_START, ENG_DONE, ENG_CLEAR_ACC;
    logic [5:0][7:0]      ENG_ADDR;
    logic [5:0]           ENG_WE, ENG_RE;
    logic [5:0][31:0]     ENG_WDATA, ENG_RDATA;
    logic [31:0]          CFG_G, CFG_NUM, EXPORT_DATA;
    logic [3:0][31:0]     DISP_RAD, DISP_POS_X, DISP_POS_Y, DISP_POS_Z;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] rd;

    body_regfile_avl dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE), .AVL_CS(AVL_CS),
        .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA),
        .AVL_READDATA(AVL_READDATA), .AVL_READDATAVALID(AVL_READDATAVALID),
        .AVL_IRQ(AVL_IRQ), .ENG_START(ENG_START), .ENG_DONE(ENG_DONE),
        .ENG_CLEAR_ACC(ENG_CLEAR_ACC), .ENG_ADDR(ENG_ADDR), .ENG_WE(ENG_WE),
        .ENG_RE(ENG_RE), .ENG_WDATA(ENG_WDATA), .ENG_RDATA(ENG_RDATA),
        .CFG_G(CFG_G), .CFG_NUM(CFG_NUM), .DISP_RAD(DISP_RAD),
        .DISP_POS_X(DISP_POS_X), .DISP_POS_Y(DISP_POS_Y), .DISP_POS_Z(DISP_POS_Z),
        .EXPORT_DATA(EXPORT_DATA)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic avl_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge CLK);
        AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = a; AVL_WRITEDATA = d; AVL_BYTE_EN = be;
        @(negedge CLK);
        AVL_CS = 1'b0; AVL_WRITE = 1'b0; AVL_BYTE_EN = 4'h0;
    endtask

    task automatic avl_rd(input logic [7:0] a, output logic [31:0] d);
        @(negedge CLK);
        AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = a;
        @(negedge CLK);
        AVL_CS = 1'b0; AVL_READ = 1'b0;
        d = AVL_READDATA;
        check("readdatavalid", 32'(AVL_READDATAVALID), 32'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N = 1'b0;
        AVL_READ = 0; AVL_WRITE = 0; AVL_CS = 0; AVL_BYTE_EN = 0; AVL_ADDR = 0; AVL_WRITEDATA = 0;
        ENG_DONE = 0; ENG_CLEAR_ACC = 0; ENG_ADDR = '0; ENG_WE = '0; ENG_RE = '0; ENG_WDATA = '0;
        @(negedge CLK); @(negedge CLK);
        check("rst_readdata", AVL_READDATA, 32'h0);
        check("rst_rdv", 32'(AVL_READDATAVALID), 32'h0);
        check("rst_irq", 32'(AVL_IRQ), 32'h0);
        check("rst_start", 32'(ENG_START), 32'h0);
        RESET_N = 1'b1;

        // Byte-enable merging and one-cycle readdatavalid
        avl_wr(8'd4, 32'hAABBCCDD, 4'b1111);
        avl_wr(8'd4, 32'h11223344, 4'b0101);
        avl_rd(8'd4, rd);
        check("be_merge_0101", rd, 32'hAA22CC44);
        @(negedge CLK);
        check("rdv_one_cycle", 32'(AVL_READDATAVALID), 32'h0);
        avl_wr(8'd4, 32'hFFFFFFFF, 4'b0000);
        avl_wr(8'd4, 32'h99000000, 4'b1000);
        avl_rd(8'd4, rd);
        check("be_merge_1000", rd, 32'h9922CC44);

        avl_wr(8'd0, 32'h12345678, 4'b1111);
        avl_wr(8'd1, 32'h00000005, 4'b1111);
        check("cfg_g", CFG_G, 32'h12345678);
        check("cfg_num", CFG_NUM, 32'h5);
        check("export_g", EXPORT_DATA, 32'h12345678);

        // Out of range (DEPTH = 114)
        avl_wr(8'd114, 32'hFFFFFFFF, 4'b1111);
        avl_rd(8'd114, rd);
        check("oor_read", rd, 32'h0);
        avl_rd(8'd4, rd);
        check("oor_no_alias", rd, 32'h9922CC44);

        // Engine access while idle is ignored
        @(negedge CLK);
        ENG_WE[0] = 1; ENG_ADDR[0] = 8'd24; ENG_WDATA[0] = 32'hDEAD;
        ENG_RE[1] = 1; ENG_ADDR[1] = 8'd4;
        @(negedge CLK);
        ENG_WE = '0; ENG_RE = '0;
        check("idle_eng_rdata", ENG_RDATA[1], 32'h0);
        avl_rd(8'd24, rd);
        check("idle_eng_write", rd, 32'h0);

        // Start handshake
        avl_wr(8'd2, 32'h3, 4'b1111);
        check("start_pulse", 32'(ENG_START), 32'h1);
        @(negedge CLK);
        check("start_one_cycle", 32'(ENG_START), 32'h0);
        avl_rd(8'd3, rd);
        check("status_busy", rd, 32'h2);
        avl_rd(8'd2, rd);
        check("ctrl_readback", rd, 32'h2);
        avl_wr(8'd2, 32'h3, 4'b1111);
        check("start_while_busy", 32'(ENG_START), 32'h0);

        // Engine read latency / hold
        @(negedge CLK);
        ENG_RE[2] = 1; ENG_ADDR[2] = 8'd4;
        @(negedge CLK);
        ENG_RE = '0; ENG_ADDR[2] = 8'd0;
        check("eng_read", ENG_RDATA[2], 32'h9922CC44);
        @(negedge CLK);
        check("eng_read_hold", ENG_RDATA[2], 32'h9922CC44);

        // Engine writes to words 0..3 ignored
        ENG_WE[1] = 1; ENG_ADDR[1] = 8'd0; ENG_WDATA[1] = 32'hBAD;
        @(negedge CLK);
        ENG_WE = '0;
        check("eng_write_g", CFG_G, 32'h12345678);

        // Collision: Avalon beats port 3 on POS_X[0]; port 5 lands on POS_Y[0]
        AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = 8'd24; AVL_WRITEDATA = 32'h5; AVL_BYTE_EN = 4'hF;
        ENG_WE[3] = 1; ENG_ADDR[3] = 8'd24; ENG_WDATA[3] = 32'h7;
        ENG_WE[5] = 1; ENG_ADDR[5] = 8'd34; ENG_WDATA[5] = 32'h9;
        @(negedge CLK);
        AVL_CS = 0; AVL_WRITE = 0; AVL_BYTE_EN = 0; ENG_WE = '0;
        check("coll_pos_x", DISP_POS_X[0], 32'h5);
        check("coll_pos_y", DISP_POS_Y[0], 32'h9);

        // Accumulator clear vs port write
        ENG_WE[0] = 1; ENG_ADDR[0] = 8'd85;  ENG_WDATA[0] = 32'h11;
        ENG_WE[1] = 1; ENG_ADDR[1] = 8'd113; ENG_WDATA[1] = 32'h22;
        @(negedge CLK);
        ENG_WE = '0;
        avl_rd(8'd85, rd);
        check("acc_preload", rd, 32'h11);
        @(negedge CLK);
        ENG_CLEAR_ACC = 1;
        ENG_WE[0] = 1; ENG_ADDR[0] = 8'd96; ENG_WDATA[0] = 32'h1234;
        ENG_WE[4] = 1; ENG_ADDR[4] = 8'd44; ENG_WDATA[4] = 32'h77;
        @(negedge CLK);
        ENG_CLEAR_ACC = 0; ENG_WE = '0;
        check("disp_pos_z", DISP_POS_Z[0], 32'h77);
        check("clear_keeps_pos", DISP_POS_X[0], 32'h5);
        avl_rd(8'd85, rd);
        check("clear_acc_x1", rd, 32'h0);
        avl_rd(8'd113, rd);
        check("clear_acc_z9", rd, 32'h0);
        avl_rd(8'd96, rd);
        check("clear_vs_port", rd, 32'h1234);

        // Done, IRQ and W1C
        @(negedge CLK);
        ENG_DONE = 1;
        @(negedge CLK);
        ENG_DONE = 0;
        check("irq_set", 32'(AVL_IRQ), 32'h1);
        avl_rd(8'd3, rd);
        check("status_done", rd, 32'h1);
        avl_wr(8'd3, 32'h1, 4'b1111);
        check("irq_clr", 32'(AVL_IRQ), 32'h0);
        ENG_DONE = 1;
        @(negedge CLK);
        ENG_DONE = 0;
        avl_rd(8'd3, rd);
        check("done_idle_ignored", rd, 32'h0);

        // Same-edge DONE and W1C: set wins
        avl_wr(8'd2, 32'h3, 4'b1111);
        @(negedge CLK);
        AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = 8'd3; AVL_WRITEDATA = 32'h1; AVL_BYTE_EN = 4'hF;
        ENG_DONE = 1;
        @(negedge CLK);
        AVL_CS = 0; AVL_WRITE = 0; AVL_BYTE_EN = 0; ENG_DONE = 0;
        avl_rd(8'd3, rd);
        check("done_set_wins", rd, 32'h1);

        // Reset mid-run
        avl_wr(8'd2, 32'h3, 4'b1111);
        check("restart_pulse", 32'(ENG_START), 32'h1);
        #2 RESET_N = 1'b0;
        #1;
        check("mid_rst_start", 32'(ENG_START), 32'h0);
        check("mid_rst_cfg_g", CFG_G, 32'h0);
        check("mid_rst_disp", DISP_POS_X[0], 32'h0);
        check("mid_rst_rdata", ENG_RDATA[2], 32'h0);
        @(negedge CLK);
        RESET_N = 1'b1;
        avl_rd(8'd3, rd);
        check("post_rst_status", rd, 32'h0);
        avl_rd(8'd0, rd);
        check("post_rst_g", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
